ula_exec_mc: RTL and testbench
==============================

Name: ula_exec_mc

Overview:
- Parametrised multi-cycle execute unit: ALUOp/func decode, the ALU datapath, and an iterative multiply/divide engine with HI/LO registers, in one block.
- Sits between the register-read stage and writeback.
- Valid/ready handshake on input and output.
- Adds unsigned/overflow variants, SRLV, the MULT/DIV family and HI/LO moves.

Parameters:
WIDTH, 32, operand/result width; power of two, 8 or more
SHW, $clog2(WIDTH), shift-amount width (derived, do not override)
HAS_MULDIV, 1, 0 removes the mul/div engine and HI/LO; those funcs then decode as illegal

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
in_valid  in  1  operation offered
in_ready  out  1  unit can accept an operation this cycle
alu_op  in  2  from main control: 00 add, 01 sub, 10 R-type, 11 reserved
func  in  6  R-type function field
shamt  in  SHW  immediate shift amount
a  in  WIDTH  rs operand
b  in  WIDTH  rt operand / immediate
out_valid  out  1  result available
out_ready  in  1  consumer takes result
result  out  WIDTH  ALU result
zero  out  1  result == 0
ovf  out  1  signed overflow on ADD/SUB
wb_en  out  1  result must be written to the register file
illegal  out  1  undecodable operation
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register

Behaviour:
- Reset (rst_n low at posedge clk):
  - state IDLE
  - out_valid, result, zero, ovf, wb_en, illegal all 0
  - hi and lo 0
  - any in-flight mul/div is aborted
- States:
  - IDLE: waiting for an operation.
  - BUSY: mul/div iterating.
  - DONE: outputs held.
- in_ready = (state==IDLE) | (state==DONE & out_ready). It is combinational.
- Accept happens on in_valid & in_ready.
  - Single-cycle op: go to DONE next cycle with out_valid=1, so latency is 1.
  - MULT, MULTU, DIV, DIVU: go to BUSY.
- In DONE, when out_ready=1 and a new input is accepted on the same edge, go directly to the next op's state. No bubble is allowed.
- In DONE with out_ready=0, all outputs are held stable.
- alu_op 00: add. alu_op 01: sub. alu_op 11: illegal.
- R-type func (alu_op 10):
  - 100000 ADD: ovf on signed overflow.
  - 100001 ADDU.
  - 100010 SUB: ovf on signed overflow.
  - 100011 SUBU.
  - 100100 AND, 100101 OR, 100110 XOR, 100111 NOR.
  - 101010 SLT: signed compare.
  - 101011 SLTU: unsigned compare.
  - 000000 SLL, 000010 SRL, 000011 SRA: shift b by shamt.
  - 000100 SLLV, 000110 SRLV, 000111 SRAV: shift b by a[SHW-1:0].
  - 010000 MFHI: result=hi. 010010 MFLO: result=lo.
  - 010001 MTHI: hi<=a. 010011 MTLO: lo<=a. Both wb_en=0.
  - 001000 JR: result 0, wb_en=0, not illegal.
  - 011000 MULT, 011001 MULTU, 011010 DIV, 011011 DIVU.
  - Any other func: illegal.
- illegal op: result 0, wb_en=0, illegal=1, latency 1.
- wb_en=1 for all ALU ops and MF*; 0 otherwise.
- ovf is 0 for every op except ADD/SUB.
- Mul/div engine:
  - Signed ops take absolute values at accept.
  - Then WIDTH iterations of shift-add (mult) or restoring division (div).
  - Then 1 sign-fix cycle.
  - Total accept-to-out_valid latency is WIDTH+1 cycles.
  - Mult: {hi,lo} = 2*WIDTH-bit product.
  - Div: lo=quotient, hi=remainder. Remainder takes the sign of the dividend; quotient truncates toward zero.
  - hi and lo are updated on the cycle out_valid rises.
  - On completion: wb_en=0, result=0.
- Divide by zero: same latency, lo=all-ones, hi=a (dividend), no flag.
- in_ready=0 throughout BUSY.

Decomposition:
- Package ula_pkg holds:
  - ALUControl encoding constants: ADD 0010, SUB 0110, AND 0000, OR 0001, XOR 0011, NOR 1100, SLT 0111, SLTU 1011, SLL 1000, SRL 1001, SRA 1010.
  - func opcode constants.
  - State enum.
- Sub-module ula_muldiv is the iterative engine. Ports: start, signed, is_div, a, b, done, hi_out, lo_out.
- Decode and the combinational ALU stay in the top module.

Test Plan:
- ADD, a=32'h7FFFFFFF, b=1, out_ready=1 -> one cycle later result=32'h80000000, ovf=1, wb_en=1; the same operands with ADDU -> ovf=0.
- SLT vs SLTU with a=32'hFFFFFFFF, b=1 -> results 1 and 0 respectively; SRAV a=4, b=32'hF0000000 -> 32'hFF000000.
- MULT a=-3, b=7 -> in_ready low for exactly 33 cycles, out_valid at cycle 33, hi=32'hFFFFFFFF, lo=32'hFFFFFFEB; following MFLO -> result 32'hFFFFFFEB.
- DIV a=-7, b=2 -> lo=-3, hi=-1; DIVU a=5, b=0 -> lo=32'hFFFFFFFF, hi=5.
- out_ready held low 4 cycles in DONE -> result/flags stable, in_ready=0; back-to-back ops with out_ready=1 -> one result per cycle.
- rst_n low at cycle 10 of a DIV -> next cycle state IDLE, out_valid=0, hi=lo=0, in_ready=1; func 111111 -> illegal=1, wb_en=0.

Source files
------------

// File: rtl/ula_exec_mc_pkg.sv
// ula_pkg: shared constants for the multi-cycle execute unit.
//   - ALUControl encodings driven by the decoder into the ALU datapath
//   - main-control alu_op codes and R-type func opcodes
//   - FSM state type for the execute unit
package ula_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLL  = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1001;
  localparam logic [3:0] ALU_SRA  = 4'b1010;
  localparam logic [3:0] ALU_SLTU = 4'b1011;
  localparam logic [3:0] ALU_NOR  = 4'b1100;

  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_SUB   = 2'b01;
  localparam logic [1:0] OP_RTYPE = 2'b10;

  localparam logic [5:0] F_SLL   = 6'b000000;
  localparam logic [5:0] F_SRL   = 6'b000010;
  localparam logic [5:0] F_SRA   = 6'b000011;
  localparam logic [5:0] F_SLLV  = 6'b000100;
  localparam logic [5:0] F_SRLV  = 6'b000110;
  localparam logic [5:0] F_SRAV  = 6'b000111;
  localparam logic [5:0] F_JR    = 6'b001000;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_ADDU  = 6'b100001;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_SUBU  = 6'b100011;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_XOR   = 6'b100110;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SLTU  = 6'b101011;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } state_t;

endpackage

// File: rtl/ula_exec_mc_if.sv
// ula_exec_mc_if: operation/result handshake bundle of the execute unit.
//   master (register-read/writeback side): in_valid, alu_op, func, shamt,
//     a, b, out_ready
//   slave (execute unit): in_ready, out_valid, result, zero, ovf, wb_en,
//     illegal, hi, lo
interface ula_exec_mc_if #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       alu_op;
  logic [5:0]       func;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             ovf;
  logic             wb_en;
  logic             illegal;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output in_valid, alu_op, func, shamt, a, b, out_ready,
    input  in_ready, out_valid, result, zero, ovf, wb_en, illegal, hi, lo
  );

  modport slave (
    input  in_valid, alu_op, func, shamt, a, b, out_ready,
    output in_ready, out_valid, result, zero, ovf, wb_en, illegal, hi, lo
  );
endinterface

// File: rtl/ula_exec_mc_muldiv.sv
// ula_muldiv: iterative multiply/divide engine.
//   clk, rst_n : clock, synchronous active-low reset (aborts a running op)
//   start      : load operands (one-cycle pulse)
//   is_signed  : treat a/b as two's complement
//   is_div     : 1 = divide, 0 = multiply
//   a, b       : operands (dividend/divisor for divide)
//   done       : high during the sign-fix cycle; hi_out/lo_out valid then
//   hi_out     : product high half / remainder
//   lo_out     : product low half / quotient
module ula_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH);

  logic             running;
  logic             div_mode;
  logic             neg_res;
  logic             neg_rem;
  logic             div0;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] p_hi;
  logic [WIDTH-1:0] p_lo;
  logic [WIDTH-1:0] opnd;

  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;
  logic [WIDTH:0]   msum;
  logic [WIDTH:0]   dshift;
  logic [WIDTH:0]   dtrial;
  logic [2*WIDTH-1:0] prod;

  // Signed operands are reduced to magnitudes so the core loop is unsigned;
  // the signs are remembered and applied in the final cycle.
  assign a_neg  = is_signed & a[WIDTH-1];
  assign b_neg  = is_signed & b[WIDTH-1];
  assign a_abs  = a_neg ? -a : a;
  assign b_abs  = b_neg ? -b : b;

  // One shift-add step: conditionally add the multiplicand into the upper
  // half, then shift the whole {carry, p_hi, p_lo} right by one.
  assign msum   = {1'b0, p_hi} + (p_lo[0] ? {1'b0, opnd} : '0);

  // One restoring-division step: bring the next dividend bit into the
  // partial remainder and try to subtract the divisor.
  assign dshift = {p_hi, p_lo[WIDTH-1]};
  assign dtrial = dshift - {1'b0, opnd};

  assign prod   = {p_hi, p_lo};
  assign done   = running && (cnt == LAST);

  // Sign fix: quotient truncates toward zero, remainder follows the
  // dividend. Divide by zero reports all-ones quotient and the dividend
  // itself as remainder (the unsigned loop already leaves |a| in p_hi).
  always_comb begin
    hi_out = '0;
    lo_out = '0;
    if (div_mode) begin
      hi_out = neg_rem ? -p_hi : p_hi;
      lo_out = div0 ? '1 : (neg_res ? -p_lo : p_lo);
    end else begin
      {hi_out, lo_out} = neg_res ? -prod : prod;
    end
  end

  // Engine sequencing: load on start, WIDTH iteration cycles, then one
  // cycle with done high after which the engine goes quiet.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      running  <= 1'b0;
      div_mode <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div0     <= 1'b0;
      cnt      <= '0;
      p_hi     <= '0;
      p_lo     <= '0;
      opnd     <= '0;
    end else if (start) begin
      running  <= 1'b1;
      div_mode <= is_div;
      neg_res  <= a_neg ^ b_neg;
      neg_rem  <= a_neg;
      div0     <= is_div && (b == '0);
      cnt      <= '0;
      p_hi     <= '0;
      p_lo     <= a_abs;
      opnd     <= b_abs;
    end else if (running) begin
      if (cnt == LAST) begin
        running <= 1'b0;
      end else begin
        cnt <= cnt + CW'(1);
        if (div_mode) begin
          if (!dtrial[WIDTH]) begin
            p_hi <= dtrial[WIDTH-1:0];
            p_lo <= {p_lo[WIDTH-2:0], 1'b1};
          end else begin
            p_hi <= dshift[WIDTH-1:0];
            p_lo <= {p_lo[WIDTH-2:0], 1'b0};
          end
        end else begin
          {p_hi, p_lo} <= {msum, p_lo[WIDTH-1:1]};
        end
      end
    end
  end
endmodule

// File: rtl/ula_exec_mc.sv
// ula_exec_mc: multi-cycle execute unit between register read and writeback.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : ula_exec_mc_if.slave -- operation in (in_valid/in_ready,
//                alu_op, func, shamt, a, b), result out (out_valid/out_ready,
//                result, zero, ovf, wb_en, illegal) and the HI/LO registers
module ula_exec_mc
  import ula_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int HAS_MULDIV = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  ula_exec_mc_if.slave  bus
);
  localparam int SHW = $clog2(WIDTH);

  state_t           state;
  logic             out_valid_r;
  logic [WIDTH-1:0] result_r;
  logic             zero_r;
  logic             ovf_r;
  logic             wb_en_r;
  logic             illegal_r;
  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] lo_r;

  logic [3:0]       alu_ctl;
  logic             var_shift;
  logic             d_ovf;
  logic             d_wb;
  logic             d_ill;
  logic             d_force0;
  logic             d_sel_hi;
  logic             d_sel_lo;
  logic             d_mthi;
  logic             d_mtlo;
  logic             d_is_md;
  logic             d_md_signed;
  logic             d_md_div;
  logic [WIDTH-1:0] d_result;

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             ovf_add;
  logic             ovf_sub;
  logic [SHW-1:0]   sh;
  logic [WIDTH-1:0] alu_res;

  logic             accept;
  logic             md_start;
  logic             md_done;
  logic [WIDTH-1:0] md_hi;
  logic [WIDTH-1:0] md_lo;

  assign bus.in_ready  = (state == ST_IDLE) || (state == ST_DONE && bus.out_ready);
  assign accept        = bus.in_valid && bus.in_ready;
  assign md_start      = accept && d_is_md;
  assign bus.out_valid = out_valid_r;
  assign bus.result    = result_r;
  assign bus.zero      = zero_r;
  assign bus.ovf       = ovf_r;
  assign bus.wb_en     = wb_en_r;
  assign bus.illegal   = illegal_r;
  assign bus.hi        = hi_r;
  assign bus.lo        = lo_r;

  assign sum     = bus.a + bus.b;
  assign diff    = bus.a - bus.b;
  assign ovf_add = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
  assign ovf_sub = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff[WIDTH-1] != bus.a[WIDTH-1]);

  // Decode: map alu_op/func onto an ALUControl code plus side-band controls.
  // Only the trapping R-type ADD/SUB report overflow; the HI/LO and mul/div
  // funcs decode as illegal when the engine is not built.
  always_comb begin
    alu_ctl     = ALU_ADD;
    var_shift   = 1'b0;
    d_ovf       = 1'b0;
    d_wb        = 1'b1;
    d_ill       = 1'b0;
    d_force0    = 1'b0;
    d_sel_hi    = 1'b0;
    d_sel_lo    = 1'b0;
    d_mthi      = 1'b0;
    d_mtlo      = 1'b0;
    d_is_md     = 1'b0;
    d_md_signed = 1'b0;
    d_md_div    = 1'b0;
    case (bus.alu_op)
      OP_ADD:   alu_ctl = ALU_ADD;
      OP_SUB:   alu_ctl = ALU_SUB;
      OP_RTYPE: begin
        case (bus.func)
          F_ADD:  begin alu_ctl = ALU_ADD; d_ovf = ovf_add; end
          F_ADDU: alu_ctl = ALU_ADD;
          F_SUB:  begin alu_ctl = ALU_SUB; d_ovf = ovf_sub; end
          F_SUBU: alu_ctl = ALU_SUB;
          F_AND:  alu_ctl = ALU_AND;
          F_OR:   alu_ctl = ALU_OR;
          F_XOR:  alu_ctl = ALU_XOR;
          F_NOR:  alu_ctl = ALU_NOR;
          F_SLT:  alu_ctl = ALU_SLT;
          F_SLTU: alu_ctl = ALU_SLTU;
          F_SLL:  alu_ctl = ALU_SLL;
          F_SRL:  alu_ctl = ALU_SRL;
          F_SRA:  alu_ctl = ALU_SRA;
          F_SLLV: begin alu_ctl = ALU_SLL; var_shift = 1'b1; end
          F_SRLV: begin alu_ctl = ALU_SRL; var_shift = 1'b1; end
          F_SRAV: begin alu_ctl = ALU_SRA; var_shift = 1'b1; end
          F_JR:   begin d_wb = 1'b0; d_force0 = 1'b0 | 1'b1; end
          F_MFHI, F_MFLO: begin
            if (HAS_MULDIV != 0) begin
              d_sel_hi = (bus.func == F_MFHI);
              d_sel_lo = (bus.func == F_MFLO);
            end else begin
              d_ill = 1'b1;
            end
          end
          F_MTHI, F_MTLO: begin
            if (HAS_MULDIV != 0) begin
              d_mthi   = (bus.func == F_MTHI);
              d_mtlo   = (bus.func == F_MTLO);
              d_wb     = 1'b0;
              d_force0 = 1'b1;
            end else begin
              d_ill = 1'b1;
            end
          end
          F_MULT, F_MULTU, F_DIV, F_DIVU: begin
            if (HAS_MULDIV != 0) begin
              d_is_md     = 1'b1;
              d_wb        = 1'b0;
              d_md_signed = !bus.func[0];
              d_md_div    = bus.func[1];
            end else begin
              d_ill = 1'b1;
            end
          end
          default: d_ill = 1'b1;
        endcase
      end
      default:  d_ill = 1'b1;
    endcase
    if (d_ill) begin
      d_wb = 1'b0;
    end
  end

  // ALU datapath driven by the decoded ALUControl code; variable shifts take
  // their amount from the low bits of a instead of shamt.
  always_comb begin
    sh = var_shift ? bus.a[SHW-1:0] : bus.shamt;
    case (alu_ctl)
      ALU_ADD:  alu_res = sum;
      ALU_SUB:  alu_res = diff;
      ALU_AND:  alu_res = bus.a & bus.b;
      ALU_OR:   alu_res = bus.a | bus.b;
      ALU_XOR:  alu_res = bus.a ^ bus.b;
      ALU_NOR:  alu_res = ~(bus.a | bus.b);
      ALU_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(bus.a) < $signed(bus.b)};
      ALU_SLTU: alu_res = {{(WIDTH-1){1'b0}}, bus.a < bus.b};
      ALU_SLL:  alu_res = bus.b << sh;
      ALU_SRL:  alu_res = bus.b >> sh;
      ALU_SRA:  alu_res = $unsigned($signed(bus.b) >>> sh);
      default:  alu_res = '0;
    endcase
  end

  // Result select: illegal ops, JR, MT* and mul/div all present zero.
  always_comb begin
    if (d_ill || d_force0 || d_is_md) begin
      d_result = '0;
    end else if (d_sel_hi) begin
      d_result = hi_r;
    end else if (d_sel_lo) begin
      d_result = lo_r;
    end else begin
      d_result = alu_res;
    end
  end

  generate
    if (HAS_MULDIV != 0) begin : g_md
      ula_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (md_start),
        .is_signed (d_md_signed),
        .is_div    (d_md_div),
        .a         (bus.a),
        .b         (bus.b),
        .done      (md_done),
        .hi_out    (md_hi),
        .lo_out    (md_lo)
      );
    end else begin : g_nomd
      assign md_done = 1'b0;
      assign md_hi   = '0;
      assign md_lo   = '0;
    end
  endgenerate

  // Control FSM with registered outputs. DONE hands its result off and may
  // accept the next op on the same edge, so back-to-back single-cycle ops
  // stream one per cycle; with out_ready low every output register holds.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      out_valid_r <= 1'b0;
      result_r    <= '0;
      zero_r      <= 1'b0;
      ovf_r       <= 1'b0;
      wb_en_r     <= 1'b0;
      illegal_r   <= 1'b0;
      hi_r        <= '0;
      lo_r        <= '0;
    end else begin
      case (state)
        ST_BUSY: begin
          if (md_done) begin
            state       <= ST_DONE;
            out_valid_r <= 1'b1;
            result_r    <= '0;
            zero_r      <= 1'b1;
            ovf_r       <= 1'b0;
            wb_en_r     <= 1'b0;
            illegal_r   <= 1'b0;
            hi_r        <= md_hi;
            lo_r        <= md_lo;
          end
        end
        default: begin
          if (state == ST_DONE && bus.out_ready) begin
            state       <= ST_IDLE;
            out_valid_r <= 1'b0;
          end
          if (accept) begin
            if (d_is_md) begin
              state       <= ST_BUSY;
              out_valid_r <= 1'b0;
            end else begin
              state       <= ST_DONE;
              out_valid_r <= 1'b1;
              result_r    <= d_result;
              zero_r      <= (d_result == '0);
              ovf_r       <= d_ovf;
              wb_en_r     <= d_wb;
              illegal_r   <= d_ill;
              if (d_mthi) begin
                hi_r <= bus.a;
              end
              if (d_mtlo) begin
                lo_r <= bus.a;
              end
            end
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ula_exec_mc.sv
// tb_ula_exec_mc: scoreboard bench for ula_exec_mc. The stimulus process
// pushes hand-computed expectations when an op is accepted; the monitor pops
// and compares whenever a result is handed off.
module tb_ula_exec_mc;
  import ula_pkg::*;

  typedef struct {
    string       name;
    logic [31:0] result;
    logic        ovf;
    logic        wb;
    logic        ill;
    logic        chk_hilo;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   lastWait;
  exp_t sb[$];

  ula_exec_mc_if #(.WIDTH(32)) bus ();

  ula_exec_mc #(.WIDTH(32), .HAS_MULDIV(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One comparison: counts it and reports a FAIL line on mismatch.
  task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Offer one op, wait (bounded) for acceptance, record its expectation.
  task automatic applyStimulus(input string nm, input logic [1:0] op, input logic [5:0] fn,
                               input logic [4:0] sh, input logic [31:0] av, input logic [31:0] bv,
                               input logic [31:0] er, input logic eo, input logic ew, input logic ei,
                               input logic ch, input logic [31:0] eh, input logic [31:0] el,
                               input bit push);
    exp_t e;
    logic rdy;
    bit   accepted;
    bus.in_valid = 1'b1;
    bus.alu_op   = op;
    bus.func     = fn;
    bus.shamt    = sh;
    bus.a        = av;
    bus.b        = bv;
    accepted     = 1'b0;
    lastWait     = 0;
    for (int n = 0; n < 200 && !accepted; n++) begin
      rdy = bus.in_ready;
      @(posedge clk);
      lastWait++;
      if (rdy) accepted = 1'b1;
    end
    if (!accepted) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s_accept actual=timeout expected=accepted", nm);
    end else if (push) begin
      e.name = nm; e.result = er; e.ovf = eo; e.wb = ew; e.ill = ei;
      e.chk_hilo = ch; e.hi = eh; e.lo = el;
      sb.push_back(e);
    end
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic alu(input string nm, input logic [1:0] op, input logic [5:0] fn,
                     input logic [4:0] sh, input logic [31:0] av, input logic [31:0] bv,
                     input logic [31:0] er, input logic eo, input logic ew, input logic ei);
    applyStimulus(nm, op, fn, sh, av, bv, er, eo, ew, ei, 1'b0, 32'h0, 32'h0, 1'b1);
  endtask

  task automatic md(input string nm, input logic [5:0] fn, input logic [31:0] av,
                    input logic [31:0] bv, input logic [31:0] eh, input logic [31:0] el);
    applyStimulus(nm, OP_RTYPE, fn, 5'd0, av, bv, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, eh, el, 1'b1);
  endtask

  // Wait (bounded) until every expected result has been handed off.
  task automatic drain();
    for (int n = 0; n < 300 && (sb.size() != 0 || bus.out_valid); n++) begin
      @(posedge clk);
      #1;
    end
    checkOutput("drain_pending", sb.size(), 0);
  endtask

  // Monitor: compare each handed-off result against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_output actual=%h expected=none", bus.result);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput({e.name, "_result"}, bus.result, e.result);
        checkOutput({e.name, "_zero"}, bus.zero, (e.result == 32'h0));
        checkOutput({e.name, "_ovf"}, bus.ovf, e.ovf);
        checkOutput({e.name, "_wb_en"}, bus.wb_en, e.wb);
        checkOutput({e.name, "_illegal"}, bus.illegal, e.ill);
        if (e.chk_hilo) begin
          checkOutput({e.name, "_hi"}, bus.hi, e.hi);
          checkOutput({e.name, "_lo"}, bus.lo, e.lo);
        end
      end
    end
  end

  // Safety net so the run always ends.
  initial begin
    #400000;
    failures++;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Directed stimulus.
  initial begin
    int cnt;
    int bad;
    checks = 0; failures = 0; lastWait = 0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    bus.alu_op = 2'b00; bus.func = 6'd0; bus.shamt = 5'd0; bus.a = 32'h0; bus.b = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_out_valid", bus.out_valid, 1'b0);
    checkOutput("reset_result", bus.result, 32'h0);
    checkOutput("reset_hi", bus.hi, 32'h0);
    checkOutput("reset_lo", bus.lo, 32'h0);
    checkOutput("reset_in_ready", bus.in_ready, 1'b1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    alu("add_ovf",  OP_RTYPE, F_ADD,  5'd0, 32'h7FFFFFFF, 32'h1, 32'h80000000, 1'b1, 1'b1, 1'b0);
    alu("addu",     OP_RTYPE, F_ADDU, 5'd0, 32'h7FFFFFFF, 32'h1, 32'h80000000, 1'b0, 1'b1, 1'b0);
    checkOutput("b2b_wait", lastWait, 1);
    alu("slt",      OP_RTYPE, F_SLT,  5'd0, 32'hFFFFFFFF, 32'h1, 32'h1, 1'b0, 1'b1, 1'b0);
    alu("sltu",     OP_RTYPE, F_SLTU, 5'd0, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b0, 1'b1, 1'b0);
    checkOutput("b2b_wait2", lastWait, 1);
    alu("srav",     OP_RTYPE, F_SRAV, 5'd0, 32'h4, 32'hF0000000, 32'hFF000000, 1'b0, 1'b1, 1'b0);
    alu("sub_ovf",  OP_RTYPE, F_SUB,  5'd0, 32'h80000000, 32'h1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0);
    alu("subu",     OP_RTYPE, F_SUBU, 5'd0, 32'h80000000, 32'h1, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0);
    alu("and",      OP_RTYPE, F_AND,  5'd0, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b1, 1'b0);
    alu("or",       OP_RTYPE, F_OR,   5'd0, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0, 1'b1, 1'b0);
    alu("xor",      OP_RTYPE, F_XOR,  5'd0, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 1'b1, 1'b0);
    alu("nor",      OP_RTYPE, F_NOR,  5'd0, 32'hF0F0F0F0, 32'hFF00FF00, 32'h000F000F, 1'b0, 1'b1, 1'b0);
    alu("sll",      OP_RTYPE, F_SLL,  5'd4, 32'h0, 32'h1, 32'h10, 1'b0, 1'b1, 1'b0);
    alu("srl",      OP_RTYPE, F_SRL,  5'd4, 32'h0, 32'hF0000000, 32'h0F000000, 1'b0, 1'b1, 1'b0);
    alu("sra",      OP_RTYPE, F_SRA,  5'd4, 32'h0, 32'hF0000000, 32'hFF000000, 1'b0, 1'b1, 1'b0);
    alu("srlv",     OP_RTYPE, F_SRLV, 5'd0, 32'h8, 32'h80000000, 32'h00800000, 1'b0, 1'b1, 1'b0);
    alu("sllv",     OP_RTYPE, F_SLLV, 5'd0, 32'h23, 32'h3, 32'h18, 1'b0, 1'b1, 1'b0);
    alu("op_add",   OP_ADD,   6'h3F,  5'd0, 32'h5, 32'h3, 32'h8, 1'b0, 1'b1, 1'b0);
    alu("op_sub",   OP_SUB,   6'h3F,  5'd0, 32'h3, 32'h3, 32'h0, 1'b0, 1'b1, 1'b0);
    alu("mthi",     OP_RTYPE, F_MTHI, 5'd0, 32'h12345678, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    alu("mfhi",     OP_RTYPE, F_MFHI, 5'd0, 32'h0, 32'h0, 32'h12345678, 1'b0, 1'b1, 1'b0);
    alu("jr",       OP_RTYPE, F_JR,   5'd0, 32'h40, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    alu("ill_func", OP_RTYPE, 6'h3F,  5'd0, 32'h1, 32'h2, 32'h0, 1'b0, 1'b0, 1'b1);
    alu("ill_op",   2'b11,    F_ADD,  5'd0, 32'h1, 32'h2, 32'h0, 1'b0, 1'b0, 1'b1);
    drain();

    md("mult", F_MULT, 32'hFFFFFFFD, 32'h7, 32'hFFFFFFFF, 32'hFFFFFFEB);
    cnt = 0; bad = 0;
    while (!bus.out_valid && cnt < 100) begin
      if (bus.in_ready !== 1'b0) bad++;
      @(posedge clk);
      #1;
      cnt++;
    end
    checkOutput("mult_latency", cnt, 33);
    checkOutput("mult_busy_in_ready", bad, 0);
    alu("mflo", OP_RTYPE, F_MFLO, 5'd0, 32'h0, 32'h0, 32'hFFFFFFEB, 1'b0, 1'b1, 1'b0);
    alu("mfhi2", OP_RTYPE, F_MFHI, 5'd0, 32'h0, 32'h0, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0);
    md("div_neg",  F_DIV,   32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    md("divu_0",   F_DIVU,  32'h5, 32'h0, 32'h5, 32'hFFFFFFFF);
    md("multu",    F_MULTU, 32'hFFFFFFFF, 32'h2, 32'h1, 32'hFFFFFFFE);
    md("div_negb", F_DIV,   32'h7, 32'hFFFFFFFE, 32'h1, 32'hFFFFFFFD);
    drain();

    bus.out_ready = 1'b0;
    alu("hold", OP_ADD, 6'h0, 5'd0, 32'h2, 32'h3, 32'h5, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("hold_result", bus.result, 32'h5);
      checkOutput("hold_out_valid", bus.out_valid, 1'b1);
      checkOutput("hold_in_ready", bus.in_ready, 1'b0);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    drain();

    applyStimulus("div_abort", OP_RTYPE, F_DIV, 5'd0, 32'd100, 32'd7, 32'h0, 1'b0, 1'b0, 1'b0,
                  1'b0, 32'h0, 32'h0, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("abort_out_valid", bus.out_valid, 1'b0);
    checkOutput("abort_hi", bus.hi, 32'h0);
    checkOutput("abort_lo", bus.lo, 32'h0);
    checkOutput("abort_in_ready", bus.in_ready, 1'b1);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid !== 1'b0) bad++;
    end
    checkOutput("abort_no_result", bad, 0);
    alu("mfhi_rst", OP_RTYPE, F_MFHI, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    alu("mflo_rst", OP_RTYPE, F_MFLO, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    alu("ill_end",  OP_RTYPE, 6'h3F,  5'd0, 32'h9, 32'h9, 32'h0, 1'b0, 1'b0, 1'b1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
